// File: rtl/dsp_bank2_sram_resp.sv
// -----------------------------------------------------------------------------
// dsp_bank2_sram_resp
//
// Purpose:
//   Responder for the DSP core's Data Memory Bank II. It owns the bank storage
//   and serves two masters:
//     * the DSP core: one registered read per cycle, one write per cycle, and
//       the DSP always owns the single write port when it strobes;
//     * a lower-priority host port (sample loader/unloader): valid/ready
//       handshake. Host writes are posted into a small FIFO. The FIFO drains
//       into the array in cycles where the DSP is not writing. Host reads
//       return registered data with a one-cycle rvalid pulse.
//
// Ports:
//   clk           single clock, rising edge
//   rst           asynchronous assert, active-high reset
//   read_addr_2   DSP read address, sampled every cycle
//   read_data_2   DSP read data, registered (latency 1)
//   write_addr_2  DSP write address
//   write_data_2  DSP write data
//   write_en_2    DSP write strobe
//   host_valid    host request valid
//   host_ready    host request accepted this cycle (when host_valid is high)
//   host_we       1 = write, 0 = read
//   host_addr     host address
//   host_wdata    host write data
//   host_rvalid   one-cycle pulse, host_rdata valid
//   host_rdata    host read data
//   host_idle     posted-write FIFO empty and no host read outstanding
// -----------------------------------------------------------------------------
module dsp_bank2_sram_resp #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_addr_2,
    output logic [DATA_W-1:0] read_data_2,
    input  logic [ADDR_W-1:0] write_addr_2,
    input  logic [DATA_W-1:0] write_data_2,
    input  logic              write_en_2,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_idle
);

    localparam int MEM_DEPTH = 1 << ADDR_W;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // Posted-write FIFO. Entries are not reset; only the pointers and count
    // define which entries are live.
    logic [ADDR_W-1:0] fifo_addr_reg [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_reg [FIFO_DEPTH];

    logic [PTR_W-1:0]  head_reg;
    logic [PTR_W-1:0]  tail_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;

    logic [DATA_W-1:0] read_data_reg;
    logic [DATA_W-1:0] host_rdata_reg;
    logic              host_rvalid_reg;
    logic              host_idle_reg;

    // -------------------------------------------------------------------------
    // Handshake and arbitration
    // -------------------------------------------------------------------------
    logic fifo_full;
    logic fifo_empty;
    logic wr_ready;
    logic rd_ready;
    logic push;
    logic rd_accept;
    logic drain;

    // Fullness is judged on the start-of-cycle count only. A drain in the same
    // cycle does not open a slot for a push, so host_ready has no path from
    // the drain decision.
    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign wr_ready   = !fifo_full;

    // Reads wait for the FIFO to empty. A read therefore never overtakes an
    // earlier posted write. The pending pulse cycle blocks a second read, so
    // at most one read is in flight.
    assign rd_ready   = fifo_empty && !write_en_2 && !host_rvalid_reg;

    assign host_ready = host_we ? wr_ready : rd_ready;
    assign push       = host_valid &&  host_we && wr_ready;
    assign rd_accept  = host_valid && !host_we && rd_ready;

    // The DSP owns the write port. The FIFO head waits for a DSP-idle cycle.
    assign drain      = !write_en_2 && !fifo_empty;

    always_comb begin
        count_next = count_reg;
        case ({push, drain})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // -------------------------------------------------------------------------
    // Single write port: DSP write, else FIFO drain
    // -------------------------------------------------------------------------
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign mem_we    = write_en_2 || drain;
    assign mem_waddr = write_en_2 ? write_addr_2 : fifo_addr_reg[head_reg];
    assign mem_wdata = write_en_2 ? write_data_2 : fifo_data_reg[head_reg];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Read ports. These non-blocking reads sample the array before the same
    // edge's write lands, so a same-address collision returns the old word.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_reg <= '0;
        end else begin
            read_data_reg <= mem[read_addr_2];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_rdata_reg  <= '0;
            host_rvalid_reg <= 1'b0;
        end else begin
            host_rvalid_reg <= rd_accept;
            if (rd_accept) begin
                host_rdata_reg <= mem[host_addr];
            end
        end
    end

    // -------------------------------------------------------------------------
    // FIFO entry storage and control
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_reg[tail_reg] <= host_addr;
            fifo_data_reg[tail_reg] <= host_wdata;
        end
    end

    // FIFO_DEPTH is a power of two, so the natural pointer overflow wraps
    // the pointers modulo the depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            host_idle_reg <= 1'b1;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (drain) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            count_reg     <= count_next;
            // Built from next-state terms. The flop then always equals
            // (count == 0) && !rvalid_pending for the current cycle.
            host_idle_reg <= (count_next == '0) && !rd_accept;
        end
    end

    assign read_data_2 = read_data_reg;
    assign host_rdata  = host_rdata_reg;
    assign host_rvalid = host_rvalid_reg;
    assign host_idle   = host_idle_reg;

endmodule
